ir_receiver: RTL

- Bus-mapped IR frame decoder: the receive end of the IR link driven by the IR transmitter peripheral.
- Samples a demodulated IR receiver output and measures burst and gap widths in timebase ticks.
- Decodes a start burst followed by NUM_BITS pulse-width-coded bits, and exposes the received byte and status on the shared BUS_DATA/BUS_ADDR/BUS_WE bus.
- Raises a processor interrupt on each completed frame.

---
 rtl/ir_receiver.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/ir_receiver.sv
// Purpose : IR frame decoder; measures burst/gap widths in timebase ticks, decodes start + NUM_BITS bits.
// Latency : DATA/VALID/SEND_INTERRUPT update 3 clocks after IR_RX_N rises at the end of the last bit.
// Backpres: none; an unread byte is overwritten and flagged as OVERRUN, the IRQ is held until acknowledged.
//
// Ports   : CLK/RESETN (async active-low) | IR_RX_N demodulated input, low = burst
//           BUS_DATA/BUS_ADDR/BUS_WE shared bus: DATA at BASE_ADDR, STATUS at BASE_ADDR+1
//           SEND_INTERRUPT frame-complete request, cleared by INTERRUPT_ACK
// Option  : define IR_GLITCH_FILTER_EN to require 3 stable ticks before the burst level changes.
module ir_receiver #(
    parameter logic [7:0] BASE_ADDR   = 8'h98,
    parameter int         TICK_CYCLES = 1000,
    parameter int         START_MIN   = 150,
    parameter int         START_MAX   = 350,
    parameter int         BIT_MIN     = 20,
    parameter int         BIT_THRESH  = 80,
    parameter int         GAP_TIMEOUT = 300,
    parameter int         NUM_BITS    = 8
) (
    input  logic       CLK,
    input  logic       RESETN,
    input  logic       IR_RX_N,
    inout  wire  [7:0] BUS_DATA,
    input  logic [7:0] BUS_ADDR,
    input  logic       BUS_WE,
    output logic       SEND_INTERRUPT,
    input  logic       INTERRUPT_ACK
);

    localparam int              TW          = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [TW-1:0]   TICK_LAST   = TW'(TICK_CYCLES - 1);
    localparam logic [11:0]     W_START_MIN = 12'(START_MIN);
    localparam logic [11:0]     W_START_MAX = 12'(START_MAX);
    localparam logic [11:0]     W_BIT_MIN   = 12'(BIT_MIN);
    localparam logic [11:0]     W_BIT_TH    = 12'(BIT_THRESH);
    localparam logic [11:0]     W_GAP_TO    = 12'(GAP_TIMEOUT);
    localparam logic [11:0]     W_SAT       = 12'hFFF;
    localparam logic [3:0]      NBITS       = 4'(NUM_BITS);
    localparam logic [7:0]      STAT_ADDR   = BASE_ADDR + 8'd1;

    typedef enum logic [2:0] {S_IDLE, S_START, S_GAP, S_BIT, S_DONE} state_t;

    state_t        state_q, state_d;
    logic          sync1_q, sync2_q;
    logic          burst, burst_prev_q;
    logic          rise, fall, tick;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic [11:0]   width_q, width_d;
    logic [7:0]    sr_q, sr_d, sr_shift, frame_byte;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic          frame_done, frame_err;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d, ovr_q, ovr_d, ferr_q, ferr_d;
    logic          irq_q, irq_d;
    logic          rd_vld_q, rd_vld_d;
    logic [7:0]    rd_dat_q, rd_dat_d;
    logic          rd_hit, rd_data_evt, wr_stat;
    logic [2:0]    clr_bits;
    logic          unused_bus_bits;

    // Timebase and burst-width measurement
    assign tick = (tick_cnt_q == TICK_LAST);

    always_comb begin
        tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
        width_d    = width_q;
        // Every edge restarts the measurement, so each burst and gap is timed on its own.
        if (rise || fall)
            width_d = '0;
        else if (tick && (width_q != W_SAT))
            width_d = width_q + 12'd1;
    end

`ifdef IR_GLITCH_FILTER_EN
    logic       filt_q, filt_d;
    logic [1:0] stab_q, stab_d;

    // The raw level must disagree with the filtered one for 3 ticks before it is accepted;
    // rise and fall are delayed equally so measured widths are preserved.
    always_comb begin
        filt_d = filt_q;
        stab_d = stab_q;
        if (~sync2_q == filt_q) begin
            stab_d = 2'd0;
        end else if (tick) begin
            if (stab_q == 2'd2) begin
                filt_d = ~sync2_q;
                stab_d = 2'd0;
            end else begin
                stab_d = stab_q + 2'd1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            filt_q <= 1'b0;
            stab_q <= 2'd0;
        end else begin
            filt_q <= filt_d;
            stab_q <= stab_d;
        end
    end

    assign burst = filt_q;
`else
    assign burst = ~sync2_q;
`endif

    assign rise = burst & ~burst_prev_q;
    assign fall = ~burst & burst_prev_q;

    // LSB-first: new bit enters at the top; a short frame ends up right-aligned by the shift below.
    assign sr_shift   = {(width_q >= W_BIT_TH), sr_q[7:1]};
    assign frame_byte = sr_shift >> (8 - NUM_BITS);

    // Frame FSM
    always_comb begin
        state_d    = state_q;
        sr_d       = sr_q;
        bit_cnt_d  = bit_cnt_q;
        frame_done = 1'b0;
        frame_err  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (rise) state_d = S_START;
            end
            S_START: begin
                if (fall) begin
                    if ((width_q >= W_START_MIN) && (width_q <= W_START_MAX)) begin
                        sr_d      = '0;
                        bit_cnt_d = '0;
                        state_d   = S_GAP;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_GAP: begin
                if (rise) begin
                    state_d = S_BIT;
                end else if (width_q >= W_GAP_TO) begin
                    frame_err = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            S_BIT: begin
                if (fall) begin
                    if (width_q < W_BIT_MIN) begin
                        frame_err = 1'b1;
                        state_d   = S_IDLE;
                    end else begin
                        sr_d      = sr_shift;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if ((bit_cnt_q + 4'd1) == NBITS) begin
                            // Result is committed on this edge; DONE is the one-cycle settle after it.
                            frame_done = 1'b1;
                            state_d    = S_DONE;
                        end else begin
                            state_d = S_GAP;
                        end
                    end
                end else if (width_q > W_START_MAX) begin
                    // Carrier stuck on: abandon without waiting for the burst to end.
                    frame_err = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Bus decode and status registers; sets take priority over same-cycle clears.
    assign rd_hit          = !BUS_WE && ((BUS_ADDR == BASE_ADDR) || (BUS_ADDR == STAT_ADDR));
    assign rd_data_evt     = !BUS_WE && (BUS_ADDR == BASE_ADDR);
    assign wr_stat         = BUS_WE && (BUS_ADDR == STAT_ADDR);
    assign clr_bits        = wr_stat ? BUS_DATA[2:0] : 3'b000;
    assign unused_bus_bits = ^BUS_DATA[7:3];

    always_comb begin
        data_d   = frame_done ? frame_byte : data_q;
        valid_d  = (valid_q & ~(rd_data_evt | clr_bits[0])) | frame_done;
        ovr_d    = (ovr_q & ~clr_bits[1]) | (frame_done & valid_q);
        ferr_d   = (ferr_q & ~clr_bits[2]) | frame_err;
        irq_d    = (irq_q & ~INTERRUPT_ACK) | frame_done;
        rd_vld_d = rd_hit;
        rd_dat_d = (BUS_ADDR == BASE_ADDR) ? data_q : {5'b0, ferr_q, ovr_q, valid_q};
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            sync1_q      <= 1'b1;
            sync2_q      <= 1'b1;
            burst_prev_q <= 1'b0;
            tick_cnt_q   <= '0;
            width_q      <= '0;
            state_q      <= S_IDLE;
            sr_q         <= '0;
            bit_cnt_q    <= '0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            ovr_q        <= 1'b0;
            ferr_q       <= 1'b0;
            irq_q        <= 1'b0;
            rd_vld_q     <= 1'b0;
            rd_dat_q     <= '0;
        end else begin
            sync1_q      <= IR_RX_N;
            sync2_q      <= sync1_q;
            burst_prev_q <= burst;
            tick_cnt_q   <= tick_cnt_d;
            width_q      <= width_d;
            state_q      <= state_d;
            sr_q         <= sr_d;
            bit_cnt_q    <= bit_cnt_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
            ovr_q        <= ovr_d;
            ferr_q       <= ferr_d;
            irq_q        <= irq_d;
            rd_vld_q     <= rd_vld_d;
            rd_dat_q     <= rd_dat_d;
        end
    end

    assign BUS_DATA       = rd_vld_q ? rd_dat_q : 8'bz;
    assign SEND_INTERRUPT = irq_q;

endmodule
